bcd_display_scan: RTL and testbench
===================================

Name: bcd_display_scan

Overview:
Time-multiplexed 3-digit 7-segment driver. Sits directly downstream of the combinational 8-bit binary-to-BCD converter and consumes its hundreds/tens/units nibbles. Captures digits on a load strobe and commits them only at frame boundaries, so the display never tears. Scans the digits with a programmable refresh rate, anti-ghosting blank time and optional leading-zero blanking.

Parameters:
REFRESH_DIV, 50000, clock cycles per digit slot (>=2)
BLANK_CYCLES, 16, cycles at the start of each slot with all anodes off (0 <= BLANK_CYCLES < REFRESH_DIV)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
hundreds  in  4  BCD hundreds digit from the converter
tens  in  4  BCD tens digit
units  in  4  BCD units digit
load  in  1  capture hundreds/tens/units into the pending register this cycle
lz_blank  in  1  enable leading-zero blanking (level, sampled every cycle)
seg  out  7  segments {g,f,e,d,c,b,a}, active-low, registered
an  out  3  digit anodes {H,T,U}, active-low one-hot, registered
frame_done  out  1  one-cycle pulse at each frame commit, registered

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: seg=7'h7F, an=3'b111, frame_done=0, prescaler cnt=0, state=DIG_U, pending=0, display=0.
- Prescaler: cnt counts 0..REFRESH_DIV-1, then wraps to 0. slot_end = (cnt==REFRESH_DIV-1).
- FSM states: DIG_U -> DIG_T -> DIG_H -> DIG_U. Advances only on slot_end. A frame is 3*REFRESH_DIV cycles.
- Pending capture: on load, pending <= {hundreds,tens,units}. Back-to-back loads: the last one wins.
- Commit: on slot_end while in DIG_H, display <= pending, and frame_done=1 on the following cycle.
  - If load coincides with the commit, display takes the live inputs directly; pending also takes them.
- Output registration: seg and an are registered from the current (state, cnt, display, lz_blank). Output lags the internal state by 1 cycle.
- Anti-ghosting: if cnt < BLANK_CYCLES, an=3'b111 and seg=7'h7F. Otherwise an drives the active digit low (U=3'b110, T=3'b101, H=3'b011).
- Decode, active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - Codes 10-15 display a dash, 7'h3F. Invalid input is never silently shown as a numeral.
- Leading-zero blanking (lz_blank=1):
  - H digit blanked (an bit stays high, seg=7F) when display.H==0.
  - T digit blanked when display.H==0 and display.T==0.
  - U is never blanked, so value 000 shows a single "0".
  - A dash digit (code >9) counts as non-zero.
- lz_blank=0: all three digits are always shown.
- Mid-operation reset: all state returns to reset values immediately. There is no partial frame or stale pending data after release.
- Parameter checks: an elaboration-time assertion fails if BLANK_CYCLES >= REFRESH_DIV or REFRESH_DIV < 2.

Decomposition:
- Package bcd_disp_pkg holds:
  - the state enum (DIG_U, DIG_T, DIG_H);
  - segment constants SEG_OFF=7'h7F and SEG_DASH=7'h3F;
  - the 10-entry digit-to-segment constant array;
  - anode one-hot constants.
- One sub-module, seg7_decode: combinational 4-bit nibble to 7-bit active-low segments, including the dash for 10-15.
- Prescaler, FSM, commit logic and blanking stay in bcd_display_scan.

Test Plan:
Test configuration is REFRESH_DIV=4, BLANK_CYCLES=1 unless stated otherwise.
1. Reset then idle, lz_blank=0 -> first frame shows 0,0,0; each slot is 1 blank cycle then 3 cycles with an=110/101/011 and seg=40; frame_done pulses every 12 cycles.
2. Load H=2,T=5,U=5 mid-frame -> display unchanged until the DIG_H slot_end; next frame shows U seg=12, T seg=12, H seg=24.
3. lz_blank=1 with loads 0/0/7, then 0/4/2, then 0/0/0:
   - 0/0/7 -> only U is lit (seg=78); H and T slots show an=111.
   - 0/4/2 -> H is blank.
   - 0/0/0 -> only U is lit, showing 40.
4. Load U=4'hB -> U slot shows seg=3F; with lz_blank=1 and H=0,T=0xC, T is not blanked and shows 3F.
5. Assert load exactly at the commit cycle with 1/2/3 -> the very next frame shows 1/2/3; load 9/9/9 then 1/1/1 in consecutive cycles -> 1/1/1 is committed.
6. Assert rst asynchronously mid-slot with display=2/5/5 -> seg=7F and an=111 immediately, without waiting for a clock; after release the frame restarts at DIG_U with display 0/0/0.

Source files
------------

// File: rtl/bcd_disp_pkg.sv
// Shared types and constants for the 3-digit multiplexed 7-segment driver.
// Segment codes are active-low in {g,f,e,d,c,b,a} order; anodes are active-low {H,T,U}.
package bcd_disp_pkg;

   typedef enum logic [1:0] {
      DIG_U = 2'd0,
      DIG_T = 2'd1,
      DIG_H = 2'd2
   } dig_state_t;

   typedef struct packed {
      logic [3:0] h;
      logic [3:0] t;
      logic [3:0] u;
   } bcd3_t;

   localparam logic [6:0] SEG_OFF  = 7'h7F;
   localparam logic [6:0] SEG_DASH = 7'h3F;

   localparam logic [6:0] SEG_DIGITS [10] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
      7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };

   localparam logic [2:0] AN_OFF = 3'b111;
   localparam logic [2:0] AN_U   = 3'b110;
   localparam logic [2:0] AN_T   = 3'b101;
   localparam logic [2:0] AN_H   = 3'b011;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-low 7-segment code.
// Non-BCD codes 10-15 render as a dash so a bad input never looks like a numeral.
module seg7_decode
   import bcd_disp_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      seg = SEG_DASH;
      if (nibble <= 4'd9) seg = SEG_DIGITS[nibble];
   end

endmodule

// File: rtl/bcd_display_scan.sv
// Time-multiplexed 3-digit 7-segment scanner with tear-free frame commit,
// anti-ghosting blank time at the start of each slot and leading-zero blanking.
module bcd_display_scan
   import bcd_disp_pkg::*;
#(
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] hundreds,
   input  logic [3:0] tens,
   input  logic [3:0] units,
   input  logic       load,
   input  logic       lz_blank,
   output logic [6:0] seg,
   output logic [2:0] an,
   output logic       frame_done
);

   if (REFRESH_DIV < 2 || BLANK_CYCLES < 0 || BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_params
      $error("bcd_display_scan: need REFRESH_DIV >= 2 and 0 <= BLANK_CYCLES < REFRESH_DIV");
   end

   localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYCLES);

   logic [CW-1:0] cnt;
   dig_state_t    state;
   bcd3_t         pending;
   bcd3_t         display;

   logic          slot_end;
   logic          commit;
   bcd3_t         live;
   logic [3:0]    cur_nib;
   logic [2:0]    cur_an;
   logic          lz_hide;
   logic          blank_now;
   logic [6:0]    dec_seg;

   assign slot_end = (cnt == CNT_LAST);
   assign commit   = slot_end && (state == DIG_H);
   assign live     = '{h: hundreds, t: tens, u: units};

   // A dash (code > 9) is non-zero, so only a literal 0 nibble can be suppressed.
   always_comb begin
      cur_nib = display.u;
      cur_an  = AN_U;
      lz_hide = 1'b0;
      case (state)
         DIG_T: begin
            cur_nib = display.t;
            cur_an  = AN_T;
            lz_hide = lz_blank && (display.h == 4'd0) && (display.t == 4'd0);
         end
         DIG_H: begin
            cur_nib = display.h;
            cur_an  = AN_H;
            lz_hide = lz_blank && (display.h == 4'd0);
         end
         default: ;
      endcase
   end

   assign blank_now = (cnt < BLANK_LIM) || lz_hide;

   seg7_decode u_decode (
      .nibble (cur_nib),
      .seg    (dec_seg)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         state      <= DIG_U;
         pending    <= '0;
         display    <= '0;
         seg        <= SEG_OFF;
         an         <= AN_OFF;
         frame_done <= 1'b0;
      end else begin
         cnt <= slot_end ? '0 : cnt + 1'b1;

         if (slot_end) begin
            case (state)
               DIG_U:   state <= DIG_T;
               DIG_T:   state <= DIG_H;
               default: state <= DIG_U;
            endcase
         end

         if (load) pending <= live;
         // A load landing on the commit edge goes straight to the display.
         if (commit) display <= load ? live : pending;
         frame_done <= commit;

         if (blank_now) begin
            seg <= SEG_OFF;
            an  <= AN_OFF;
         end else begin
            seg <= dec_seg;
            an  <= cur_an;
         end
      end
   end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench for bcd_display_scan: a cycle model pushes expected outputs
// on each rising edge; the falling-edge sampler pops and compares them.
module tb_bcd_display_scan;

   localparam int RD = 4;
   localparam int BC = 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] hundreds = '0;
   logic [3:0] tens = '0;
   logic [3:0] units = '0;
   logic       load = 1'b0;
   logic       lz_blank = 1'b0;
   logic [6:0] seg;
   logic [2:0] an;
   logic       frame_done;

   bcd_display_scan #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
      .clk        (clk),
      .rst        (rst),
      .hundreds   (hundreds),
      .tens       (tens),
      .units      (units),
      .load       (load),
      .lz_blank   (lz_blank),
      .seg        (seg),
      .an         (an),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   typedef struct packed {
      logic [6:0] seg;
      logic [2:0] an;
      logic       fd;
   } exp_t;

   exp_t sb[$];

   function automatic logic [6:0] ref_seg(input logic [3:0] d);
      case (d)
         4'd0: return 7'h40;
         4'd1: return 7'h79;
         4'd2: return 7'h24;
         4'd3: return 7'h30;
         4'd4: return 7'h19;
         4'd5: return 7'h12;
         4'd6: return 7'h02;
         4'd7: return 7'h78;
         4'd8: return 7'h00;
         4'd9: return 7'h10;
         default: return 7'h3F;
      endcase
   endfunction

   // Reference model: slot index 0=U, 1=T, 2=H; display/pending as {H,T,U} nibbles.
   initial begin
      int         m_cnt;
      int         m_slot;
      logic [11:0] m_pend;
      logic [11:0] m_disp;
      m_cnt = 0; m_slot = 0; m_pend = '0; m_disp = '0;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            sb.delete();
            m_cnt = 0; m_slot = 0; m_pend = '0; m_disp = '0;
         end else begin
            exp_t       e;
            logic [3:0] d;
            logic       blank;
            logic       cm;
            d = (m_slot == 0) ? m_disp[3:0] : (m_slot == 1) ? m_disp[7:4] : m_disp[11:8];
            blank = (m_cnt < BC);
            if (lz_blank && m_slot == 2 && m_disp[11:8] == 4'd0) blank = 1'b1;
            if (lz_blank && m_slot == 1 && m_disp[11:8] == 4'd0 && m_disp[7:4] == 4'd0) blank = 1'b1;
            cm = (m_cnt == RD - 1) && (m_slot == 2);
            e.seg = blank ? 7'h7F : ref_seg(d);
            e.an  = blank ? 3'b111 : (m_slot == 0) ? 3'b110 : (m_slot == 1) ? 3'b101 : 3'b011;
            e.fd  = cm;
            sb.push_back(e);
            if (cm) m_disp = load ? {hundreds, tens, units} : m_pend;
            if (load) m_pend = {hundreds, tens, units};
            if (m_cnt == RD - 1) begin
               m_cnt  = 0;
               m_slot = (m_slot + 1) % 3;
            end else begin
               m_cnt++;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check($sformatf("seg t=%0t", $time), 32'(seg), 32'(e.seg));
            check($sformatf("an t=%0t", $time), 32'(an), 32'(e.an));
            check($sformatf("frame_done t=%0t", $time), 32'(frame_done), 32'(e.fd));
         end
      end
   end

   task automatic load3(input logic [3:0] h, input logic [3:0] t, input logic [3:0] u);
      @(negedge clk);
      hundreds = h; tens = t; units = u; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic wait_fd(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         seen = frame_done;
      end
      check(tag, 32'(seen), 32'd1);
   endtask

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      longint t0;
      longint t1;

      // Reset state
      run(2);
      check("rst_seg", 32'(seg), 32'h7F);
      check("rst_an", 32'(an), 32'b111);
      check("rst_fd", 32'(frame_done), 32'd0);
      rst = 1'b0;

      // Idle frames of zeros, frame period
      wait_fd("fd_first");
      t0 = $time;
      wait_fd("fd_second");
      t1 = $time;
      check("fd_period", 32'((t1 - t0) / 10), 32'd12);
      run(6);

      // Mid-frame load of 2/5/5
      load3(4'd2, 4'd5, 4'd5);
      run(30);

      // Leading-zero blanking
      lz_blank = 1'b1;
      load3(4'd0, 4'd0, 4'd7);
      run(26);
      load3(4'd0, 4'd4, 4'd2);
      run(26);
      load3(4'd0, 4'd0, 4'd0);
      run(26);

      // Dash codes, dash counts as non-zero for blanking
      lz_blank = 1'b0;
      load3(4'd1, 4'd2, 4'hB);
      run(26);
      lz_blank = 1'b1;
      load3(4'd0, 4'hC, 4'd3);
      run(26);
      lz_blank = 1'b0;

      // Load on the commit edge goes straight to the display
      wait_fd("fd_sync");
      run(10);
      load3(4'd1, 4'd2, 4'd3);
      check("commit_align", 32'(frame_done), 32'd1);
      run(26);

      // Back-to-back loads: last wins
      @(negedge clk);
      hundreds = 4'd9; tens = 4'd9; units = 4'd9; load = 1'b1;
      @(negedge clk);
      hundreds = 4'd1; tens = 4'd1; units = 4'd1;
      @(negedge clk);
      load = 1'b0;
      run(26);

      // Asynchronous reset mid-slot with 2/5/5 on display
      load3(4'd2, 4'd5, 4'd5);
      run(14);
      wait_fd("fd_before_rst");
      @(posedge clk);
      @(posedge clk);
      #2;
      check("pre_rst_an", 32'(an), 32'b110);
      rst = 1'b1;
      #1;
      check("async_rst_seg", 32'(seg), 32'h7F);
      check("async_rst_an", 32'(an), 32'b111);
      check("async_rst_fd", 32'(frame_done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run(30);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
